char_rom_arbiter: RTL and testbench
===================================

// Module: char_rom_arbiter
// PURPOSE
//  Shares the single-port 4096x8 character generator memory (256 chars x 16 rows, synchronous read,
//  1-cycle latency) between the VGA text pixel pipeline and a Wishbone slave used by the CPU for
//  font load/readback. Video has priority; a starvation counter guarantees CPU forward progress.
//  Sits between the text-mode fetch unit and the char generator memory in the VGA block.
// PARAMETERS
//  STARVE_LIMIT  64  cycles a pending CPU request may wait before it steals one video slot (1..255)
//  FONT_WR_EN    1   1: CPU writes reach memory; 0: writes are acked but discarded (ROM mode)
// PORTS
//  clk        in   1   system clock
//  rst_n      in   1   asynchronous reset, active low
//  vid_req    in   1   video fetch request this cycle
//  vid_char   in   8   character code
//  vid_row    in   4   scanline within character
//  vid_valid  out  1   vid_data valid (1 cycle after granted vid_req)
//  vid_miss   out  1   pulse: video slot stolen by CPU (aligned with where vid_valid would be)
//  vid_data   out  8   pixel row bits (= mem_rdata)
//  wb_cyc_i   in   1   Wishbone cycle
//  wb_stb_i   in   1   Wishbone strobe
//  wb_we_i    in   1   1 = write
//  wb_adr_i   in   12  font address {char[7:0], row[3:0]}
//  wb_dat_i   in   8   write data
//  wb_dat_o   out  8   read data, registered, valid with wb_ack_o
//  wb_ack_o   out  1   single-cycle acknowledge
//  mem_cs     out  1   memory enable
//  mem_we     out  1   memory write enable (active high)
//  mem_addr   out  12  memory address
//  mem_wdata  out  8   memory write data
//  mem_rdata  in   8   memory read data (reflects previous cycle's access)
// BEHAVIOUR
//  - Reset: FSM=IDLE, starve_cnt=0, vid_valid=0, vid_miss=0, wb_ack_o=0, wb_dat_o=0;
//    mem_cs/mem_we=0. In-flight access abandoned, no ack; a write already clocked stays committed.
//  - Grant, decided combinationally per cycle:
//    cpu_go = IDLE & wb_cyc_i & wb_stb_i & (!vid_req | starve_cnt==STARVE_LIMIT).
//    If cpu_go: mem_addr=wb_adr_i, mem_we=wb_we_i&FONT_WR_EN, mem_wdata=wb_dat_i, mem_cs=1.
//    Else if vid_req: mem_addr={vid_char,vid_row}, mem_we=0, mem_cs=1. Else mem_cs=0.
//  - Video: granted vid_req at cycle t -> vid_valid=1 at t+1, vid_data=mem_rdata. Back-to-back
//    requests give one result per cycle. Request dropped by cpu_go -> vid_miss=1 at t+1, vid_valid=0.
//  - FSM: IDLE -> (cpu_go & write) ACK; IDLE -> (cpu_go & read) RDWAIT;
//    RDWAIT -> ACK, capturing wb_dat_o<=mem_rdata; ACK -> IDLE.
//    wb_ack_o=1 exactly in ACK and only if wb_cyc_i&wb_stb_i still high; if master dropped
//    cyc/stb, no ack and FSM still returns to IDLE. Write latency: ack at t+1; read: ack at t+2.
//    No new CPU issue in RDWAIT or ACK; next CPU access earliest in the cycle after ACK.
//  - Starvation: in IDLE, starve_cnt increments (saturating at STARVE_LIMIT) each cycle a CPU
//    request is pending but not granted; cleared on cpu_go or when cyc/stb low. So a CPU request
//    facing continuous vid_req is granted on its (STARVE_LIMIT+1)th pending cycle.
//  - vid_data is undefined when vid_valid=0. vid_req is never stalled; video has no backpressure.
//  - FONT_WR_EN=0: write cycles still follow IDLE->ACK timing; mem_we held 0.
// TESTING
//  1. vid_req held 4 cycles, chars 0x41 row 3..6 -> mem_addr 0x413..0x416; vid_valid 4 cycles
//     from t+1, vid_data 0xC6,0xC6,0xFE,0xC6 (font 'A').
//  2. CPU write adr 0x800 data 0x5A, vid idle -> mem_we=1 same cycle, ack at t+1; read 0x800 ->
//     ack at t+2, wb_dat_o=0x5A.
//  3. vid_req continuous, CPU read pending, STARVE_LIMIT=4 -> grant on 5th pending cycle,
//     vid_miss one pulse, ack 2 cycles after grant, starve_cnt back to 0.
//  4. CPU read issued, wb_stb_i dropped in RDWAIT -> no wb_ack_o; FSM IDLE after 2 cycles;
//     next request served normally.
//  5. rst_n asserted during RDWAIT -> outputs 0 immediately (async); after release, read 0x413
//     completes with correct data.
//  6. FONT_WR_EN=0: write 0x413<=0xFF -> ack at t+1, mem_we never 1; readback returns 0xC6.

Source files
------------

// File: rtl/char_rom_arbiter.sv
// Arbitrates the single-port character generator memory between the video fetch path
// (priority) and a Wishbone slave for font load/readback, with a starvation guard for the CPU.
module char_rom_arbiter #(
  parameter int unsigned STARVE_LIMIT = 64,
  parameter bit          FONT_WR_EN   = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vid_req,
  input  logic [7:0]  vid_char,
  input  logic [3:0]  vid_row,
  output logic        vid_valid,
  output logic        vid_miss,
  output logic [7:0]  vid_data,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [11:0] wb_adr_i,
  input  logic [7:0]  wb_dat_i,
  output logic [7:0]  wb_dat_o,
  output logic        wb_ack_o,
  output logic        mem_cs,
  output logic        mem_we,
  output logic [11:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RDWAIT = 2'b01,
    ACK    = 2'b10
  } state_t;

  localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

  state_t      state_r;
  state_t      state_nxt_s;
  logic [7:0]  starve_cnt_r;
  logic [7:0]  starve_nxt_s;
  logic        vid_valid_r;
  logic        vid_miss_r;
  logic [7:0]  wb_dat_r;
  logic        cpu_pend_s;
  logic        cpu_go_s;
  logic        mem_cs_s;
  logic        mem_we_s;
  logic [11:0] mem_addr_s;
  logic [7:0]  mem_wdata_s;

  // Per-cycle grant: CPU only when video is idle or the CPU has waited its full budget.
  always_comb begin
    cpu_pend_s  = wb_cyc_i & wb_stb_i;
    cpu_go_s    = (state_r == IDLE) && cpu_pend_s && (!vid_req || (starve_cnt_r == STARVE_MAX));
    mem_cs_s    = 1'b0;
    mem_we_s    = 1'b0;
    mem_addr_s  = 12'h000;
    mem_wdata_s = 8'h00;
    if (cpu_go_s) begin
      mem_cs_s    = 1'b1;
      mem_we_s    = wb_we_i & FONT_WR_EN;
      mem_addr_s  = wb_adr_i;
      mem_wdata_s = wb_dat_i;
    end else if (vid_req) begin
      mem_cs_s    = 1'b1;
      mem_addr_s  = {vid_char, vid_row};
    end else begin
      mem_cs_s    = 1'b0;
    end
  end

  // FSM next state and starvation counter update.
  always_comb begin
    state_nxt_s  = state_r;
    starve_nxt_s = 8'd0;
    case (state_r)
      IDLE: begin
        if (cpu_go_s) begin
          state_nxt_s = wb_we_i ? ACK : RDWAIT;
        end else begin
          state_nxt_s = IDLE;
        end
        if (cpu_pend_s && !cpu_go_s) begin
          starve_nxt_s = (starve_cnt_r == STARVE_MAX) ? starve_cnt_r : (starve_cnt_r + 8'd1);
        end else begin
          starve_nxt_s = 8'd0;
        end
      end
      RDWAIT:  state_nxt_s = ACK;
      ACK:     state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, counter and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      starve_cnt_r <= 8'd0;
      vid_valid_r  <= 1'b0;
      vid_miss_r   <= 1'b0;
      wb_dat_r     <= 8'h00;
    end else begin
      state_r      <= state_nxt_s;
      starve_cnt_r <= starve_nxt_s;
      vid_valid_r  <= vid_req & ~cpu_go_s;
      vid_miss_r   <= vid_req & cpu_go_s;
      if (state_r == RDWAIT) begin
        wb_dat_r <= mem_rdata;
      end else begin
        wb_dat_r <= wb_dat_r;
      end
    end
  end

  // Memory strobes are forced low while reset is held so no access leaks out.
  assign mem_cs    = mem_cs_s & rst_n;
  assign mem_we    = mem_we_s & rst_n;
  assign mem_addr  = mem_addr_s;
  assign mem_wdata = mem_wdata_s;

  assign vid_valid = vid_valid_r;
  assign vid_miss  = vid_miss_r;
  assign vid_data  = mem_rdata;
  assign wb_dat_o  = wb_dat_r;
  assign wb_ack_o  = (state_r == ACK) & wb_cyc_i & wb_stb_i;

endmodule

// File: tb/tb_char_rom_arbiter.sv
// Directed bench: two arbiters (font writable and ROM mode) share stimulus, each with its own memory.
module tb_char_rom_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vid_req = 1'b0;
  logic [7:0]  vid_char = 8'h00;
  logic [3:0]  vid_row = 4'h0;
  logic        wb_cyc_i = 1'b0;
  logic        wb_stb_i = 1'b0;
  logic        wb_we_i = 1'b0;
  logic [11:0] wb_adr_i = 12'h000;
  logic [7:0]  wb_dat_i = 8'h00;

  logic        vid_valid, vid_miss, wb_ack_o, mem_cs, mem_we;
  logic [7:0]  vid_data, wb_dat_o, mem_wdata;
  logic [11:0] mem_addr;
  logic [7:0]  mem_rdata = 8'h00;

  logic        r_vid_valid, r_vid_miss, r_wb_ack_o, r_mem_cs, r_mem_we;
  logic [7:0]  r_vid_data, r_wb_dat_o, r_mem_wdata;
  logic [11:0] r_mem_addr;
  logic [7:0]  r_mem_rdata = 8'h00;

  logic [7:0]  mem_a [0:4095];
  logic [7:0]  mem_b [0:4095];
  logic        rom_we_seen = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  char_rom_arbiter #(.STARVE_LIMIT(4), .FONT_WR_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .vid_req(vid_req), .vid_char(vid_char), .vid_row(vid_row),
    .vid_valid(vid_valid), .vid_miss(vid_miss), .vid_data(vid_data),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i), .wb_adr_i(wb_adr_i),
    .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  char_rom_arbiter #(.STARVE_LIMIT(4), .FONT_WR_EN(1'b0)) dut_rom (
    .clk(clk), .rst_n(rst_n), .vid_req(vid_req), .vid_char(vid_char), .vid_row(vid_row),
    .vid_valid(r_vid_valid), .vid_miss(r_vid_miss), .vid_data(r_vid_data),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i), .wb_adr_i(wb_adr_i),
    .wb_dat_i(wb_dat_i), .wb_dat_o(r_wb_dat_o), .wb_ack_o(r_wb_ack_o),
    .mem_cs(r_mem_cs), .mem_we(r_mem_we), .mem_addr(r_mem_addr), .mem_wdata(r_mem_wdata),
    .mem_rdata(r_mem_rdata)
  );

  // Synchronous single-port memories with 1-cycle read latency, font 'A' rows 3..6 preloaded.
  initial begin
    for (int a = 0; a < 4096; a++) begin
      mem_a[a] = 8'h00;
      mem_b[a] = 8'h00;
    end
    mem_a[12'h413] = 8'hC6; mem_a[12'h414] = 8'hC6; mem_a[12'h415] = 8'hFE; mem_a[12'h416] = 8'hC6;
    mem_b[12'h413] = 8'hC6; mem_b[12'h414] = 8'hC6; mem_b[12'h415] = 8'hFE; mem_b[12'h416] = 8'hC6;
    forever begin
      @(posedge clk);
      if (mem_cs) begin
        if (mem_we) mem_a[mem_addr] <= mem_wdata;
        mem_rdata <= mem_a[mem_addr];
      end
      if (r_mem_cs) begin
        if (r_mem_we) mem_b[r_mem_addr] <= r_mem_wdata;
        r_mem_rdata <= mem_b[r_mem_addr];
      end
    end
  end

  always @(posedge clk) begin
    if (r_mem_we === 1'b1) rom_we_seen <= 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  task automatic test_reset();
    @(negedge clk);
    checks++; if (vid_valid !== 1'b0) begin errors++; $display("FAIL rst_vid_valid got %b exp 0", vid_valid); end
    checks++; if (vid_miss !== 1'b0) begin errors++; $display("FAIL rst_vid_miss got %b exp 0", vid_miss); end
    checks++; if (wb_ack_o !== 1'b0) begin errors++; $display("FAIL rst_ack got %b exp 0", wb_ack_o); end
    checks++; if (wb_dat_o !== 8'h00) begin errors++; $display("FAIL rst_dat got %h exp 00", wb_dat_o); end
    vid_req = 1'b1; wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
    #1;
    checks++; if (mem_cs !== 1'b0) begin errors++; $display("FAIL rst_mem_cs got %b exp 0", mem_cs); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we got %b exp 0", mem_we); end
    @(negedge clk);
    vid_req = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_video();
    logic [7:0] exp_d [0:3];
    exp_d[0] = 8'hC6; exp_d[1] = 8'hC6; exp_d[2] = 8'hFE; exp_d[3] = 8'hC6;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i > 0) begin
        checks++; if (vid_valid !== 1'b1) begin errors++; $display("FAIL vid_valid[%0d] got %b exp 1", i - 1, vid_valid); end
        checks++; if (vid_data !== exp_d[i - 1]) begin errors++; $display("FAIL vid_data[%0d] got %h exp %h", i - 1, vid_data, exp_d[i - 1]); end
      end
      if (i < 4) begin
        vid_req = 1'b1; vid_char = 8'h41; vid_row = 4'(3 + i);
        #1;
        checks++; if (mem_addr !== 12'(12'h413 + i) || mem_cs !== 1'b1 || mem_we !== 1'b0) begin
          errors++; $display("FAIL vid_addr[%0d] got %h cs %b we %b exp %h cs 1 we 0", i, mem_addr, mem_cs, mem_we, 12'(12'h413 + i));
        end
      end else begin
        vid_req = 1'b0;
      end
    end
    @(negedge clk);
    checks++; if (vid_valid !== 1'b0 || vid_miss !== 1'b0) begin errors++; $display("FAIL vid_idle got valid %b miss %b exp 0 0", vid_valid, vid_miss); end
  endtask

  task automatic test_write_read();
    @(negedge clk);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_adr_i = 12'h800; wb_dat_i = 8'h5A;
    #1;
    checks++; if (mem_we !== 1'b1 || mem_cs !== 1'b1 || mem_addr !== 12'h800 || mem_wdata !== 8'h5A) begin
      errors++; $display("FAIL wr_issue got we %b cs %b adr %h dat %h exp 1 1 800 5a", mem_we, mem_cs, mem_addr, mem_wdata);
    end
    checks++; if (wb_ack_o !== 1'b0) begin errors++; $display("FAIL wr_early_ack got %b exp 0", wb_ack_o); end
    @(negedge clk);
    checks++; if (wb_ack_o !== 1'b1) begin errors++; $display("FAIL wr_ack got %b exp 1", wb_ack_o); end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    @(negedge clk);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 12'h800;
    #1;
    checks++; if (mem_cs !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 12'h800) begin
      errors++; $display("FAIL rd_issue got cs %b we %b adr %h exp 1 0 800", mem_cs, mem_we, mem_addr);
    end
    @(negedge clk);
    checks++; if (wb_ack_o !== 1'b0) begin errors++; $display("FAIL rd_t1_ack got %b exp 0", wb_ack_o); end
    @(negedge clk);
    checks++; if (wb_ack_o !== 1'b1 || wb_dat_o !== 8'h5A) begin errors++; $display("FAIL rd_ack got ack %b dat %h exp 1 5a", wb_ack_o, wb_dat_o); end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    @(negedge clk);
    checks++; if (wb_ack_o !== 1'b0) begin errors++; $display("FAIL rd_after_ack got %b exp 0", wb_ack_o); end
  endtask

  task automatic test_starvation();
    @(negedge clk);
    vid_req = 1'b1; vid_char = 8'h20; vid_row = 4'h0;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 12'h415;
    for (int k = 1; k <= 5; k++) begin
      if (k > 1) @(negedge clk);
      #1;
      if (k < 5) begin
        checks++; if (mem_addr !== 12'h200) begin errors++; $display("FAIL starve_wait[%0d] got adr %h exp 200", k, mem_addr); end
      end else begin
        checks++; if (mem_addr !== 12'h415 || mem_cs !== 1'b1) begin errors++; $display("FAIL starve_grant got adr %h cs %b exp 415 1", mem_addr, mem_cs); end
      end
    end
    @(negedge clk);
    checks++; if (vid_miss !== 1'b1 || vid_valid !== 1'b0) begin errors++; $display("FAIL starve_miss got miss %b valid %b exp 1 0", vid_miss, vid_valid); end
    checks++; if (wb_ack_o !== 1'b0) begin errors++; $display("FAIL starve_early_ack got %b exp 0", wb_ack_o); end
    @(negedge clk);
    checks++; if (wb_ack_o !== 1'b1 || wb_dat_o !== 8'hFE) begin errors++; $display("FAIL starve_ack got ack %b dat %h exp 1 fe", wb_ack_o, wb_dat_o); end
    checks++; if (vid_miss !== 1'b0 || vid_valid !== 1'b1) begin errors++; $display("FAIL starve_single_miss got miss %b valid %b exp 0 1", vid_miss, vid_valid); end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    @(negedge clk);
    checks++; if (dut.starve_cnt_r !== 8'd0) begin errors++; $display("FAIL starve_cnt_clear got %0d exp 0", dut.starve_cnt_r); end
    vid_req = 1'b0;
  endtask

  task automatic test_abort();
    @(negedge clk);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 12'h413;
    @(negedge clk);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    @(negedge clk);
    checks++; if (wb_ack_o !== 1'b0) begin errors++; $display("FAIL abort_no_ack got %b exp 0", wb_ack_o); end
    @(negedge clk);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_adr_i = 12'h414;
    #1;
    checks++; if (mem_cs !== 1'b1 || mem_addr !== 12'h414) begin errors++; $display("FAIL abort_reissue got cs %b adr %h exp 1 414", mem_cs, mem_addr); end
    @(negedge clk);
    @(negedge clk);
    checks++; if (wb_ack_o !== 1'b1 || wb_dat_o !== 8'hC6) begin errors++; $display("FAIL abort_next_rd got ack %b dat %h exp 1 c6", wb_ack_o, wb_dat_o); end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 12'h800;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (wb_dat_o !== 8'h00) begin errors++; $display("FAIL async_dat got %h exp 00", wb_dat_o); end
    checks++; if (wb_ack_o !== 1'b0 || mem_cs !== 1'b0 || vid_valid !== 1'b0) begin
      errors++; $display("FAIL async_out got ack %b cs %b valid %b exp 0 0 0", wb_ack_o, mem_cs, vid_valid);
    end
    @(negedge clk);
    checks++; if (wb_ack_o !== 1'b0) begin errors++; $display("FAIL async_hold_ack got %b exp 0", wb_ack_o); end
    wb_adr_i = 12'h413;
    rst_n = 1'b1;
    #1;
    checks++; if (mem_cs !== 1'b1 || mem_addr !== 12'h413) begin errors++; $display("FAIL async_reissue got cs %b adr %h exp 1 413", mem_cs, mem_addr); end
    @(negedge clk);
    checks++; if (wb_ack_o !== 1'b0) begin errors++; $display("FAIL async_t1_ack got %b exp 0", wb_ack_o); end
    @(negedge clk);
    checks++; if (wb_ack_o !== 1'b1 || wb_dat_o !== 8'hC6) begin errors++; $display("FAIL async_rd got ack %b dat %h exp 1 c6", wb_ack_o, wb_dat_o); end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
  endtask

  task automatic test_rom_mode();
    @(negedge clk);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_adr_i = 12'h413; wb_dat_i = 8'hFF;
    #1;
    checks++; if (r_mem_we !== 1'b0 || r_mem_cs !== 1'b1) begin errors++; $display("FAIL rom_wr_issue got we %b cs %b exp 0 1", r_mem_we, r_mem_cs); end
    @(negedge clk);
    checks++; if (r_wb_ack_o !== 1'b1) begin errors++; $display("FAIL rom_wr_ack got %b exp 1", r_wb_ack_o); end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    @(negedge clk);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_adr_i = 12'h413;
    @(negedge clk);
    @(negedge clk);
    checks++; if (r_wb_ack_o !== 1'b1 || r_wb_dat_o !== 8'hC6) begin errors++; $display("FAIL rom_readback got ack %b dat %h exp 1 c6", r_wb_ack_o, r_wb_dat_o); end
    checks++; if (wb_ack_o !== 1'b1 || wb_dat_o !== 8'hFF) begin errors++; $display("FAIL ram_readback got ack %b dat %h exp 1 ff", wb_ack_o, wb_dat_o); end
    checks++; if (rom_we_seen !== 1'b0) begin errors++; $display("FAIL rom_we_never got %b exp 0", rom_we_seen); end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_video();
    test_write_read();
    test_starvation();
    test_abort();
    test_async_reset();
    test_rom_mode();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
